// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared types and helpers for the RISC-V debug bus-module APB4 interface unit.
package peripheral_dbg_pu_riscv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SETUP,
      ACCESS,
      DONE
   } biu_apb4_state_t;

   // Privileged, secure, data access.
   localparam logic [2:0] DBG_APB4_PPROT = 3'b001;

   function automatic logic dbg_size_legal(input logic [3:0] size, input int data_w);
      case (size)
         4'd1, 4'd2, 4'd4: return 1'b1;
         4'd8:             return (data_w == 64);
         default:          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/peripheral_dbg_pu_riscv_biu_sync.sv
// Two-flop level synchroniser with asynchronous active-low reset.
module peripheral_dbg_pu_riscv_biu_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[0], i_d};
   end

   assign o_q = r_sync[1];

endmodule

// File: rtl/peripheral_dbg_pu_riscv_biu_apb4.sv
// APB4 master for the debug bus-module: one SETUP/ACCESS transfer per biu_strb rise,
// with byte-lane steering, alignment checking and a PREADY timeout.
module peripheral_dbg_pu_riscv_biu_apb4
   import peripheral_dbg_pu_riscv_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    biu_strb,
   input  logic                    biu_rw,
   input  logic [ADDR_WIDTH-1:0]   biu_addr,
   input  logic [DATA_WIDTH-1:0]   biu_di,
   input  logic [3:0]              biu_word_size,
   output logic [DATA_WIDTH-1:0]   biu_do,
   output logic                    biu_rdy,
   output logic                    biu_err,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic                    PWRITE,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [2:0]              PPROT,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LANE_W = $clog2(STRB_W);
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   biu_apb4_state_t r_state, w_state_nxt;

   logic                  w_strb_s;
   logic                  r_strb_d;
   logic                  w_strb_rise;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_di;
   logic                  r_rw;
   logic [3:0]            r_size;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_do;
   logic [LANE_W-1:0]     w_lane;
   logic                  w_legal;
   logic                  w_timeout;
   logic [15:0]           w_strb_full;
   logic [15:0]           w_strb_sh;
   logic [DATA_WIDTH-1:0] w_dmask;

   peripheral_dbg_pu_riscv_biu_sync u_strb_sync (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_d     (biu_strb),
      .o_q     (w_strb_s)
   );

   assign w_strb_rise = w_strb_s & ~r_strb_d;
   assign w_lane      = r_addr[LANE_W-1:0];
   // Aligned means no lane bits set below the access size.
   assign w_legal     = dbg_size_legal(r_size, DATA_WIDTH) &&
                        (({{(4-LANE_W){1'b0}}, w_lane} & (r_size - 4'd1)) == 4'd0);
   assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_strb_full = (16'd1 << r_size) - 16'd1;
   assign w_strb_sh   = w_strb_full << w_lane;
   assign w_dmask     = ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << {r_size, 3'b000}) -
                        {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   assign PSEL    = (r_state == SETUP) || (r_state == ACCESS);
   assign PENABLE = (r_state == ACCESS);
   assign PADDR   = r_addr;
   assign PWRITE  = r_rw;
   assign PWDATA  = r_di << {w_lane, 3'b000};
   assign PSTRB   = r_rw ? w_strb_sh[STRB_W-1:0] : '0;
   assign PPROT   = DBG_APB4_PPROT;
   assign biu_rdy = (r_state == DONE);
   assign biu_err = r_err;
   assign biu_do  = r_do;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state  <= IDLE;
         r_strb_d <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_strb_d <= w_strb_s;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_strb_rise) w_state_nxt = CHECK;
         CHECK:   w_state_nxt = w_legal ? SETUP : DONE;
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  if (PREADY || w_timeout) w_state_nxt = DONE;
         DONE:    if (!w_strb_s) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_addr <= '0;
         r_di   <= '0;
         r_rw   <= 1'b0;
         r_size <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
         r_do   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_strb_rise) begin
                  r_addr <= biu_addr;
                  r_di   <= biu_di;
                  r_rw   <= biu_rw;
                  r_size <= biu_word_size;
               end
            end
            CHECK:  if (!w_legal) r_err <= 1'b1;
            SETUP:  r_cnt <= '0;
            ACCESS: begin
               if (PREADY) begin
                  r_err <= PSLVERR;
                  if (!PSLVERR) r_do <= (PRDATA >> {w_lane, 3'b000}) & w_dmask;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_timeout) r_err <= 1'b1;
               end
            end
            DONE:   if (!w_strb_s) r_err <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_biu_apb4.sv
// Self-checking bench for the debug-bus APB4 interface unit with a small APB slave model.
module tb_peripheral_dbg_pu_riscv_biu_apb4;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        biu_strb;
   logic        biu_rw;
   logic [31:0] biu_addr;
   logic [31:0] biu_di;
   logic [3:0]  biu_word_size;
   logic [31:0] biu_do;
   logic        biu_rdy;
   logic        biu_err;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [2:0]  PPROT;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   peripheral_dbg_pu_riscv_biu_apb4 #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .biu_strb      (biu_strb),
      .biu_rw        (biu_rw),
      .biu_addr      (biu_addr),
      .biu_di        (biu_di),
      .biu_word_size (biu_word_size),
      .biu_do        (biu_do),
      .biu_rdy       (biu_rdy),
      .biu_err       (biu_err),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PADDR         (PADDR),
      .PWRITE        (PWRITE),
      .PWDATA        (PWDATA),
      .PSTRB         (PSTRB),
      .PPROT         (PPROT),
      .PRDATA        (PRDATA),
      .PREADY        (PREADY),
      .PSLVERR       (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // APB slave model: PREADY after wait_states ACCESS cycles unless stuck.
   int          wait_states = 0;
   bit          stuck = 1'b0;
   logic [31:0] slv_rdata = '0;
   logic        slv_err = 1'b0;
   int          wcnt;

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)             wcnt <= 0;
      else if (PSEL && PENABLE) wcnt <= wcnt + 1;
      else                      wcnt <= 0;
   end

   assign PREADY  = PSEL && PENABLE && !stuck && (wcnt >= wait_states);
   assign PRDATA  = slv_rdata;
   assign PSLVERR = slv_err;

   typedef struct {
      bit          bus;
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          access;
      logic        err;
      logic [31:0] dout;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   int errors = 0;
   int checks = 0;

   int          obs_setup_at, obs_rdy_at, obs_access, obs_unstable;
   logic [31:0] obs_paddr, obs_pwdata, obs_do;
   logic        obs_pwrite, obs_err, obs_psel_at_rdy;
   logic [3:0]  obs_pstrb;

   task automatic run_req(input logic rw, input logic [31:0] addr, input logic [31:0] di,
                          input logic [3:0] size, input bit drop_early);
      @(negedge PCLK);
      biu_rw = rw; biu_addr = addr; biu_di = di; biu_word_size = size; biu_strb = 1'b1;
      obs_setup_at = -1; obs_rdy_at = -1; obs_access = 0; obs_unstable = 0;
      obs_paddr = 'x; obs_pwdata = 'x; obs_pstrb = 'x; obs_pwrite = 'x;
      obs_err = 'x; obs_do = 'x; obs_psel_at_rdy = 'x;
      for (int i = 1; i <= 100; i++) begin
         @(negedge PCLK);
         if (PSEL && !PENABLE && obs_setup_at < 0) begin
            obs_setup_at = i;
            obs_paddr = PADDR; obs_pwrite = PWRITE; obs_pwdata = PWDATA; obs_pstrb = PSTRB;
         end
         if (PSEL && PENABLE) begin
            obs_access++;
            if (PADDR !== obs_paddr || PWRITE !== obs_pwrite || PWDATA !== obs_pwdata ||
                PSTRB !== obs_pstrb) obs_unstable++;
            if (drop_early) biu_strb = 1'b0;
         end
         if (biu_rdy) begin
            obs_rdy_at = i; obs_err = biu_err; obs_do = biu_do; obs_psel_at_rdy = PSEL;
            break;
         end
      end
   endtask

   task automatic end_req();
      @(negedge PCLK);
      biu_strb = 1'b0;
      repeat (4) @(negedge PCLK);
   endtask

   task automatic test_reset();
      checks++; if (PSEL !== 1'b0)     begin errors++; $display("FAIL rst_psel got=%b exp=0", PSEL); end
      checks++; if (PENABLE !== 1'b0)  begin errors++; $display("FAIL rst_penable got=%b exp=0", PENABLE); end
      checks++; if (PWRITE !== 1'b0)   begin errors++; $display("FAIL rst_pwrite got=%b exp=0", PWRITE); end
      checks++; if (PADDR !== 32'h0)   begin errors++; $display("FAIL rst_paddr got=%h exp=0", PADDR); end
      checks++; if (PWDATA !== 32'h0)  begin errors++; $display("FAIL rst_pwdata got=%h exp=0", PWDATA); end
      checks++; if (PSTRB !== 4'h0)    begin errors++; $display("FAIL rst_pstrb got=%h exp=0", PSTRB); end
      checks++; if (PPROT !== 3'b001)  begin errors++; $display("FAIL rst_pprot got=%b exp=001", PPROT); end
      checks++; if (biu_do !== 32'h0)  begin errors++; $display("FAIL rst_do got=%h exp=0", biu_do); end
      checks++; if (biu_rdy !== 1'b0)  begin errors++; $display("FAIL rst_rdy got=%b exp=0", biu_rdy); end
      checks++; if (biu_err !== 1'b0)  begin errors++; $display("FAIL rst_err got=%b exp=0", biu_err); end
   endtask

   // Common bus-cycle checks are written out in each scenario.
   task automatic test_write_word();
      exp_q.push_back('{bus:1, addr:32'h1000, write:1'b1, wdata:32'hDEADBEEF, strb:4'hF,
                        access:1, err:1'b0, dout:'0});
      wait_states = 0; slv_err = 1'b0;
      run_req(1'b1, 32'h1000, 32'hDEADBEEF, 4'd4, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_setup_at !== 4) begin errors++; $display("FAIL ww_latency got=%0d exp=4", obs_setup_at); end
      checks++; if (obs_rdy_at !== obs_setup_at + 2) begin errors++; $display("FAIL ww_rdy_at got=%0d exp=%0d", obs_rdy_at, obs_setup_at + 2); end
      checks++; if (obs_paddr !== e.addr)   begin errors++; $display("FAIL ww_paddr got=%h exp=%h", obs_paddr, e.addr); end
      checks++; if (obs_pwrite !== e.write) begin errors++; $display("FAIL ww_pwrite got=%b exp=%b", obs_pwrite, e.write); end
      checks++; if (obs_pwdata !== e.wdata) begin errors++; $display("FAIL ww_pwdata got=%h exp=%h", obs_pwdata, e.wdata); end
      checks++; if (obs_pstrb !== e.strb)   begin errors++; $display("FAIL ww_pstrb got=%h exp=%h", obs_pstrb, e.strb); end
      checks++; if (obs_access !== e.access) begin errors++; $display("FAIL ww_access got=%0d exp=%0d", obs_access, e.access); end
      checks++; if (obs_err !== e.err)      begin errors++; $display("FAIL ww_err got=%b exp=%b", obs_err, e.err); end
      @(negedge PCLK);
      checks++; if (biu_rdy !== 1'b1) begin errors++; $display("FAIL ww_rdy_hold got=%b exp=1", biu_rdy); end
      end_req();
      checks++; if (biu_rdy !== 1'b0) begin errors++; $display("FAIL ww_rdy_clear got=%b exp=0", biu_rdy); end
   endtask

   task automatic test_read_byte_wait();
      exp_q.push_back('{bus:1, addr:32'h2003, write:1'b0, wdata:'0, strb:4'h0,
                        access:4, err:1'b0, dout:32'h000000AB});
      wait_states = 3; slv_rdata = 32'hAB000000;
      run_req(1'b0, 32'h2003, 32'h0, 4'd1, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_pstrb !== e.strb)    begin errors++; $display("FAIL rb_pstrb got=%h exp=%h", obs_pstrb, e.strb); end
      checks++; if (obs_paddr !== e.addr)    begin errors++; $display("FAIL rb_paddr got=%h exp=%h", obs_paddr, e.addr); end
      checks++; if (obs_access !== e.access) begin errors++; $display("FAIL rb_access got=%0d exp=%0d", obs_access, e.access); end
      checks++; if (obs_unstable !== 0)      begin errors++; $display("FAIL rb_stable got=%0d exp=0", obs_unstable); end
      checks++; if (obs_do !== e.dout)       begin errors++; $display("FAIL rb_do got=%h exp=%h", obs_do, e.dout); end
      checks++; if (obs_err !== e.err)       begin errors++; $display("FAIL rb_err got=%b exp=%b", obs_err, e.err); end
      end_req();
   endtask

   task automatic test_misaligned();
      exp_q.push_back('{bus:0, addr:'0, write:1'b1, wdata:'0, strb:'0, access:0, err:1'b1, dout:32'h000000AB});
      exp_q.push_back('{bus:0, addr:'0, write:1'b0, wdata:'0, strb:'0, access:0, err:1'b1, dout:32'h000000AB});
      run_req(1'b1, 32'h2001, 32'h1234, 4'd2, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_setup_at !== -1) begin errors++; $display("FAIL mis_psel got=%0d exp=-1", obs_setup_at); end
      checks++; if (obs_rdy_at < 0 || obs_err !== e.err) begin errors++; $display("FAIL mis_err got=%b exp=%b", obs_err, e.err); end
      checks++; if (obs_do !== e.dout) begin errors++; $display("FAIL mis_do got=%h exp=%h", obs_do, e.dout); end
      end_req();
      run_req(1'b0, 32'h2000, 32'h0, 4'd3, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_setup_at !== -1) begin errors++; $display("FAIL size3_psel got=%0d exp=-1", obs_setup_at); end
      checks++; if (obs_rdy_at < 0 || obs_err !== e.err) begin errors++; $display("FAIL size3_err got=%b exp=%b", obs_err, e.err); end
      end_req();
      checks++; if (biu_err !== 1'b0) begin errors++; $display("FAIL mis_err_clear got=%b exp=0", biu_err); end
   endtask

   task automatic test_slverr();
      exp_q.push_back('{bus:1, addr:32'h3000, write:1'b0, wdata:'0, strb:'0, access:1, err:1'b1, dout:32'h000000AB});
      wait_states = 0; slv_rdata = 32'h55555555; slv_err = 1'b1;
      run_req(1'b0, 32'h3000, 32'h0, 4'd4, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_err !== e.err)  begin errors++; $display("FAIL slv_err got=%b exp=%b", obs_err, e.err); end
      checks++; if (obs_do !== e.dout)  begin errors++; $display("FAIL slv_do got=%h exp=%h", obs_do, e.dout); end
      slv_err = 1'b0;
      end_req();
   endtask

   task automatic test_timeout();
      exp_q.push_back('{bus:1, addr:32'h3004, write:1'b0, wdata:'0, strb:'0, access:8, err:1'b1, dout:32'h000000AB});
      stuck = 1'b1;
      run_req(1'b0, 32'h3004, 32'h0, 4'd4, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_access !== e.access) begin errors++; $display("FAIL to_access got=%0d exp=%0d", obs_access, e.access); end
      checks++; if (obs_psel_at_rdy !== 1'b0) begin errors++; $display("FAIL to_psel_drop got=%b exp=0", obs_psel_at_rdy); end
      checks++; if (obs_err !== e.err) begin errors++; $display("FAIL to_err got=%b exp=%b", obs_err, e.err); end
      checks++; if (obs_do !== e.dout) begin errors++; $display("FAIL to_do got=%h exp=%h", obs_do, e.dout); end
      stuck = 1'b0;
      end_req();
   endtask

   task automatic test_write_half();
      exp_q.push_back('{bus:1, addr:32'h2002, write:1'b1, wdata:32'h12340000, strb:4'hC,
                        access:1, err:1'b0, dout:'0});
      wait_states = 0;
      run_req(1'b1, 32'h2002, 32'h00001234, 4'd2, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_pstrb !== e.strb)   begin errors++; $display("FAIL wh_pstrb got=%h exp=%h", obs_pstrb, e.strb); end
      checks++; if (obs_pwdata !== e.wdata) begin errors++; $display("FAIL wh_pwdata got=%h exp=%h", obs_pwdata, e.wdata); end
      checks++; if (obs_paddr !== e.addr)   begin errors++; $display("FAIL wh_paddr got=%h exp=%h", obs_paddr, e.addr); end
      checks++; if (obs_err !== e.err)      begin errors++; $display("FAIL wh_err got=%b exp=%b", obs_err, e.err); end
      end_req();
   endtask

   task automatic test_strb_drop();
      exp_q.push_back('{bus:1, addr:32'h5000, write:1'b0, wdata:'0, strb:'0, access:5, err:1'b0, dout:32'h0BADF00D});
      wait_states = 4; slv_rdata = 32'h0BADF00D;
      run_req(1'b0, 32'h5000, 32'h0, 4'd4, 1'b1);
      e = exp_q.pop_front();
      checks++; if (obs_access !== e.access) begin errors++; $display("FAIL sd_access got=%0d exp=%0d", obs_access, e.access); end
      checks++; if (obs_rdy_at < 0 || obs_do !== e.dout) begin errors++; $display("FAIL sd_do got=%h exp=%h", obs_do, e.dout); end
      @(negedge PCLK);
      checks++; if (biu_rdy !== 1'b0) begin errors++; $display("FAIL sd_rdy_pulse got=%b exp=0", biu_rdy); end
      wait_states = 0;
      end_req();
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      int psel_after = 0;
      wait_states = 6;
      @(negedge PCLK);
      biu_rw = 1'b1; biu_addr = 32'h6000; biu_di = 32'h11112222; biu_word_size = 4'd4; biu_strb = 1'b1;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge PCLK);
         if (PSEL && PENABLE) seen = 1;
      end
      checks++; if (seen !== 1) begin errors++; $display("FAIL rm_access got=%0d exp=1", seen); end
      PRESETn = 1'b0; biu_strb = 1'b0;
      #1;
      checks++; if (PSEL !== 1'b0)    begin errors++; $display("FAIL rm_psel got=%b exp=0", PSEL); end
      checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL rm_penable got=%b exp=0", PENABLE); end
      checks++; if (PADDR !== 32'h0)  begin errors++; $display("FAIL rm_paddr got=%h exp=0", PADDR); end
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         if (PSEL || biu_rdy) psel_after++;
      end
      checks++; if (psel_after !== 0) begin errors++; $display("FAIL rm_idle got=%0d exp=0", psel_after); end
      wait_states = 0;
   endtask

   task automatic test_back_to_back();
      exp_q.push_back('{bus:1, addr:32'h4000, write:1'b0, wdata:'0, strb:'0, access:1, err:1'b0, dout:32'hCAFEF00D});
      exp_q.push_back('{bus:1, addr:32'h4002, write:1'b0, wdata:'0, strb:'0, access:1, err:1'b0, dout:32'h00001234});
      slv_rdata = 32'hCAFEF00D;
      run_req(1'b0, 32'h4000, 32'h0, 4'd4, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_setup_at !== 4) begin errors++; $display("FAIL bb1_latency got=%0d exp=4", obs_setup_at); end
      checks++; if (obs_do !== e.dout) begin errors++; $display("FAIL bb1_do got=%h exp=%h", obs_do, e.dout); end
      end_req();
      slv_rdata = 32'h12345678;
      run_req(1'b0, 32'h4002, 32'h0, 4'd2, 1'b0);
      e = exp_q.pop_front();
      checks++; if (obs_paddr !== e.addr) begin errors++; $display("FAIL bb2_paddr got=%h exp=%h", obs_paddr, e.addr); end
      checks++; if (obs_do !== e.dout) begin errors++; $display("FAIL bb2_do got=%h exp=%h", obs_do, e.dout); end
      end_req();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESETn = 1'b0; biu_strb = 1'b0; biu_rw = 1'b0; biu_addr = '0; biu_di = '0; biu_word_size = '0;
      repeat (3) @(negedge PCLK);
      test_reset();
      PRESETn = 1'b1;
      repeat (2) @(negedge PCLK);
      test_write_word();
      test_read_byte_wait();
      test_misaligned();
      test_slverr();
      test_timeout();
      test_write_half();
      test_strb_drop();
      test_reset_mid();
      test_back_to_back();
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_empty got=%0d exp=0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
